// File: rtl/csa_candidate_gen.sv
// Iterative carry-select candidate generator: computes a+b and a+b+1 one SLICE per cycle,
// then holds both candidates under a valid/ready handshake.
module csa_candidate_gen #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum0_o,
    output logic             cout0_o,
    output logic [WIDTH-1:0] sum1_o,
    output logic             cout1_o
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned IdxW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NSLICE - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e                        state_q;
    logic [NSLICE-1:0][SLICE-1:0] a_q;
    logic [NSLICE-1:0][SLICE-1:0] b_q;
    logic [NSLICE-1:0][SLICE-1:0] sum0_q;
    logic [NSLICE-1:0][SLICE-1:0] sum1_q;
    logic [IdxW-1:0]              idx_q;
    logic                         c0_q;
    logic                         c1_q;
    logic                         cout0_q;
    logic                         cout1_q;

    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE:0]   s0;
    logic [SLICE:0]   s1;

    // Both candidates share the operand slice; only the incoming carry differs.
    always_comb begin
        a_sl = a_q[idx_q];
        b_sl = b_q[idx_q];
        s0   = {1'b0, a_sl} + {1'b0, b_sl} + (SLICE + 1)'(c0_q);
        s1   = {1'b0, a_sl} + {1'b0, b_sl} + (SLICE + 1)'(c1_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum0_q  <= '0;
            sum1_q  <= '0;
            idx_q   <= '0;
            c0_q    <= 1'b0;
            c1_q    <= 1'b0;
            cout0_q <= 1'b0;
            cout1_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        idx_q   <= '0;
                        c0_q    <= 1'b0;
                        c1_q    <= 1'b1;
                        state_q <= StCalc;
                    end
                end
                StCalc: begin
                    sum0_q[idx_q] <= s0[SLICE-1:0];
                    sum1_q[idx_q] <= s1[SLICE-1:0];
                    c0_q          <= s0[SLICE];
                    c1_q          <= s1[SLICE];
                    if (idx_q == LastIdx) begin
                        cout0_q <= s0[SLICE];
                        cout1_q <= s1[SLICE];
                        state_q <= StDone;
                    end else begin
                        idx_q <= idx_q + IdxW'(1);
                    end
                end
                StDone: begin
                    // Handoff edge never accepts; a new pair is taken from IDLE only.
                    if (out_ready_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready_o  = (state_q == StIdle);
    assign out_valid_o = (state_q == StDone);
    assign sum0_o      = sum0_q;
    assign sum1_o      = sum1_q;
    assign cout0_o     = cout0_q;
    assign cout1_o     = cout1_q;

endmodule

// File: doc/csa_candidate_gen.md
Name: csa_candidate_gen

Overview:
- Iterative, handshaked producer for the carry-select sum-select stage.
- Takes one operand pair, computes both candidate results (carry-in 0 and carry-in 1) SLICE bits per cycle, then presents them together.
- Outputs map directly onto the downstream select stage: sum0/cout0 are the carry-in-0 candidate, sum1/cout1 the carry-in-1 candidate.

Parameters:
- WIDTH, 32, operand and sum width in bits.
- SLICE, 8, bits added per cycle; WIDTH must be a multiple of SLICE.
- NSLICE (derived, not overridable), WIDTH/SLICE, number of compute cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair a/b is valid.
- in_ready  output  1  block can accept an operand pair.
- a  input  WIDTH  operand A, sampled on acceptance.
- b  input  WIDTH  operand B, sampled on acceptance.
- out_valid  output  1  candidate results valid.
- out_ready  input  1  downstream consumes the results.
- sum0  output  WIDTH  a+b with carry-in 0.
- cout0  output  1  carry out of sum0.
- sum1  output  WIDTH  a+b with carry-in 1.
- cout1  output  1  carry out of sum1.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (rst_n=0, effective immediately, no clock needed):
  - state=IDLE; in_ready=1; out_valid=0.
  - sum0=0, sum1=0, cout0=0, cout1=0.
  - operand registers, slice index and internal carries cleared.
- States: IDLE, CALC, DONE.
- in_ready=1 only in IDLE; out_valid=1 only in DONE. Both are registered-state decodes with no combinational path from inputs.
- IDLE:
  - On in_valid=1 at an edge: latch a and b; slice index=0; internal carries c0=0, c1=1; go to CALC.
  - Otherwise stay in IDLE.
- CALC, one slice per edge at index i:
  - Bits [i*SLICE +: SLICE] of sum0 = a_slice + b_slice + c0, and c0 takes that slice's carry.
  - Bits [i*SLICE +: SLICE] of sum1 = a_slice + b_slice + c1, and c1 takes that slice's carry.
  - Slices are written in place.
  - After slice NSLICE-1: cout0 = final c0, cout1 = final c1, go to DONE.
  - Inputs a, b and in_valid are ignored throughout CALC.
- Latency:
  - Acceptance edge = k. out_valid rises after edge k+NSLICE (4 cycles at defaults).
  - Minimum initiation interval is NSLICE+2 cycles.
- DONE:
  - sum0, sum1, cout0 and cout1 are held stable while out_ready=0, with no limit on the stall.
  - On out_ready=1 at an edge: go to IDLE. That same edge does not accept a new operand pair.
- After handoff, sum0/sum1/cout0/cout1 keep their last values until the next CALC overwrites them. Consumers must qualify with out_valid.
- Arithmetic invariants, checked in DONE:
  - {cout0,sum0} = a+b, in WIDTH+1 bits.
  - {cout1,sum1} = a+b+1, in WIDTH+1 bits.
  - cout0=1 implies cout1=1.
- Partial sums are visible on sum0/sum1 during CALC. Their values are undefined for consumers.
- Reset asserted mid-CALC or in DONE: the operation is aborted, all values return to reset state, and no out_valid pulse is produced.
- NSLICE=1 (SLICE=WIDTH) is legal and gives a single CALC cycle.

Test Plan:
- Basic add (a=0x00000005, b=0x00000003, out_ready=1): out_valid after 4 edges; sum0=0x00000008, cout0=0, sum1=0x00000009, cout1=0; then returns to IDLE with in_ready=1.
- Carry wrap (a=0xFFFFFFFF, b=0x00000000): sum0=0xFFFFFFFF, cout0=0; sum1=0x00000000, cout1=1.
- Full overflow (a=0x80000000, b=0x80000000): sum0=0x00000000, cout0=1; sum1=0x00000001, cout1=1.
- Backpressure (a=0x12345678, b=0x11111111, out_ready=0 for 10 cycles):
  - out_valid stays 1 and sum0=0x23456789, sum1=0x2345678A stay stable throughout.
  - in_ready=0 throughout, and a changing in_valid/a/b is ignored.
  - out_ready=1 for one edge returns the block to IDLE.
- Reset mid-operation (accept a=0x0000FFFF, b=0x00000001; drop rst_n after 2 CALC edges): all outputs 0 immediately, in_ready=1, out_valid never pulses. A following op with a=1, b=1 yields sum0=2, sum1=3.
- Randomized back-to-back (1000 pairs, random out_ready): every DONE satisfies both arithmetic invariants; accepted-pair count equals handed-off count.
